// File: rtl/hd_downsizer.sv
// Handshake width-down converter: splits each DATA_WIDTH word into RATIO OUT_WIDTH beats.
// The next word is accepted on the same edge the current word's last beat is consumed.
module hd_downsizer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data_src,
    output logic                  ready_output,
    output logic                  valid_output,
    output logic [OUT_WIDTH-1:0]  data_dest,
    output logic                  last_output,
    input  logic                  ready
);

    localparam int unsigned Ratio = DATA_WIDTH / OUT_WIDTH;
    localparam int unsigned CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Ratio - 1);

    // Widths that do not split evenly into at least two beats are rejected at elaboration.
    if ((DATA_WIDTH % OUT_WIDTH) != 0 || Ratio < 2) begin : g_param_check
        $fatal(1, "hd_downsizer: DATA_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    typedef enum logic [0:0] {
        StEmpty,
        StSend
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    last_beat;
    logic [CntW-1:0]         sel;

    // Output decode: beat validity, last-beat flag and upstream ready.
    always_comb begin
        valid_output = (state_q == StSend);
        last_beat    = (state_q == StSend) && (cnt_q == CntLast);
        last_output  = last_beat;
        ready_output = rst && ((state_q == StEmpty) || (ready && last_beat));
    end

    // Beat slice selection; MSB_FIRST walks the word from the top slice down.
    always_comb begin
        sel       = MSB_FIRST ? (CntLast - cnt_q) : cnt_q;
        data_dest = '0;
        for (int unsigned i = 0; i < Ratio; i++) begin
            if (sel == CntW'(i)) begin
                data_dest = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Next-state: load a word when empty or on the last consumed beat, otherwise step the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            StEmpty: begin
                if (valid) begin
                    hold_d  = data_src;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (ready) begin
                    if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        if (valid) begin
                            hold_d = data_src;
                        end else begin
                            state_d = StEmpty;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_hd_downsizer.sv
// Directed bench for hd_downsizer: LSB-first instance for most steps, MSB-first instance for one.
module tb_hd_downsizer;

    logic        clk;
    logic        rst;

    logic        valid0, ready0, rdy_out0, vld_out0, last0;
    logic [31:0] data0;
    logic [7:0]  dest0;

    logic        valid1, ready1, rdy_out1, vld_out1, last1;
    logic [31:0] data1;
    logic [7:0]  dest1;

    int checks = 0;
    int errors = 0;

    hd_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid0),
        .data_src     (data0),
        .ready_output (rdy_out0),
        .valid_output (vld_out0),
        .data_dest    (dest0),
        .last_output  (last0),
        .ready        (ready0)
    );

    hd_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid1),
        .data_src     (data1),
        .ready_output (rdy_out1),
        .valid_output (vld_out1),
        .data_dest    (dest1),
        .last_output  (last1),
        .ready        (ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat0(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, ".valid"}, {31'b0, vld_out0}, {31'b0, v});
        chk({tag, ".data"},  {24'b0, dest0},    {24'b0, d});
        chk({tag, ".last"},  {31'b0, last0},    {31'b0, l});
    endtask

    task automatic beat1(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, ".valid"}, {31'b0, vld_out1}, {31'b0, v});
        chk({tag, ".data"},  {24'b0, dest1},    {24'b0, d});
        chk({tag, ".last"},  {31'b0, last1},    {31'b0, l});
    endtask

    initial begin
        logic [7:0] exp_b;

        // 1: reset held with valid asserted
        rst    = 1'b0;
        valid0 = 1'b1;
        data0  = 32'hAABBCCDD;
        ready0 = 1'b1;
        valid1 = 1'b0;
        data1  = 32'h0;
        ready1 = 1'b1;
        step();
        step();
        beat0("rst", 1'b0, 8'h00, 1'b0);
        chk("rst.ready_output", {31'b0, rdy_out0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel.ready_output", {31'b0, rdy_out0}, 32'd1);

        // 2: single word, LSB first
        step();
        valid0 = 1'b0;
        beat0("w1.b0", 1'b1, 8'hDD, 1'b0);
        chk("w1.b0.ready_output", {31'b0, rdy_out0}, 32'd0);
        step();
        beat0("w1.b1", 1'b1, 8'hCC, 1'b0);
        step();
        beat0("w1.b2", 1'b1, 8'hBB, 1'b0);
        step();
        beat0("w1.b3", 1'b1, 8'hAA, 1'b1);
        chk("w1.b3.ready_output", {31'b0, rdy_out0}, 32'd1);
        step();
        beat0("w1.idle", 1'b0, 8'hDD, 1'b0);

        // 3: back-to-back words, no bubble
        valid0 = 1'b1;
        data0  = 32'h03020100;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) data0 = 32'h07060504;
            if (i == 4) valid0 = 1'b0;
            exp_b = 8'(i);
            beat0($sformatf("b2b.%0d", i), 1'b1, exp_b, (i == 3) || (i == 7));
            if (i == 3) chk("b2b.3.ready_output", {31'b0, rdy_out0}, 32'd1);
        end
        step();
        beat0("b2b.idle", 1'b0, 8'h04, 1'b0);

        // 4: downstream stall on the second beat
        valid0 = 1'b1;
        data0  = 32'hAABBCCDD;
        step();
        valid0 = 1'b0;
        beat0("st.b0", 1'b1, 8'hDD, 1'b0);
        step();
        ready0 = 1'b0;
        beat0("st.b1", 1'b1, 8'hCC, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            beat0($sformatf("st.hold%0d", i), 1'b1, 8'hCC, 1'b0);
            chk($sformatf("st.hold%0d.ready_output", i), {31'b0, rdy_out0}, 32'd0);
        end
        ready0 = 1'b1;
        step();
        beat0("st.b2", 1'b1, 8'hBB, 1'b0);
        step();
        beat0("st.b3", 1'b1, 8'hAA, 1'b1);
        step();
        beat0("st.idle", 1'b0, 8'hDD, 1'b0);

        // 5: MSB-first instance
        valid1 = 1'b1;
        data1  = 32'hAABBCCDD;
        step();
        valid1 = 1'b0;
        beat1("msb.b0", 1'b1, 8'hAA, 1'b0);
        step();
        beat1("msb.b1", 1'b1, 8'hBB, 1'b0);
        step();
        beat1("msb.b2", 1'b1, 8'hCC, 1'b0);
        step();
        beat1("msb.b3", 1'b1, 8'hDD, 1'b1);
        step();
        chk("msb.idle.valid", {31'b0, vld_out1}, 32'd0);

        // 6: asynchronous reset mid-word, then a fresh word
        valid0 = 1'b1;
        data0  = 32'h11223344;
        step();
        valid0 = 1'b0;
        beat0("mr.b0", 1'b1, 8'h44, 1'b0);
        step();
        beat0("mr.b1", 1'b1, 8'h33, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        beat0("mr.rst", 1'b0, 8'h00, 1'b0);
        chk("mr.rst.ready_output", {31'b0, rdy_out0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr.rel.ready_output", {31'b0, rdy_out0}, 32'd1);
        valid0 = 1'b1;
        data0  = 32'h55667788;
        step();
        valid0 = 1'b0;
        beat0("mr.w.b0", 1'b1, 8'h88, 1'b0);
        step();
        beat0("mr.w.b1", 1'b1, 8'h77, 1'b0);
        step();
        beat0("mr.w.b2", 1'b1, 8'h66, 1'b0);
        step();
        beat0("mr.w.b3", 1'b1, 8'h55, 1'b1);
        step();
        chk("mr.idle.valid", {31'b0, vld_out0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
